// File: rtl/booth_seq_multiplier_if.sv
// Handshake and result bundle between the MIPS control unit and the Booth multiplier.
// When MULT_UNSIGNED_EN is defined, the bundle also carries unsigned_op (multu select).
interface booth_seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             start;
`ifdef MULT_UNSIGNED_EN
  logic             unsigned_op;
`endif
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             done;
  logic             busy;

`ifdef MULT_UNSIGNED_EN
  modport master (output start, unsigned_op, op_a, op_b,
                  input  hi_out, lo_out, done, busy);
  modport slave  (input  start, unsigned_op, op_a, op_b,
                  output hi_out, lo_out, done, busy);
`else
  modport master (output start, op_a, op_b,
                  input  hi_out, lo_out, done, busy);
  modport slave  (input  start, op_a, op_b,
                  output hi_out, lo_out, done, busy);
`endif
endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier executing MIPS mult, one Booth step per clock.
// Optional feature macro: MULT_UNSIGNED_EN adds multu support via the unsigned_op input.
module booth_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   reset,
  booth_seq_multiplier_if.slave bus
);
`ifdef MULT_UNSIGNED_EN
  // One guard bit lets multu run as a (WIDTH+1)-bit signed Booth product.
  localparam int XW = WIDTH + 1;
`else
  localparam int XW = WIDTH;
`endif
  localparam int AW = 2 * XW + 1;
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     m_q;
  logic [AW-1:0]     acc_q;
  logic [AW-1:0]     acc_step;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     last_step;
  logic [XW:0]       upper_ext;
  logic [XW:0]       m_ext;
  logic [XW:0]       upper_sum;
  logic [XW-1:0]     a_ext;
  logic [XW-1:0]     b_ext;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]  hi_q, lo_q;
  logic              done_q, busy_q;
  logic              unused_acc;

`ifdef MULT_UNSIGNED_EN
  logic uns_q;

  assign a_ext     = bus.unsigned_op ? {1'b0, bus.op_a} : {bus.op_a[WIDTH-1], bus.op_a};
  assign b_ext     = bus.unsigned_op ? {1'b0, bus.op_b} : {bus.op_b[WIDTH-1], bus.op_b};
  assign last_step = uns_q ? CW'(WIDTH) : CW'(WIDTH - 1);
  // Signed ops stop one step short, so the product sits one bit higher in acc.
  assign product   = uns_q ? acc_step[2*WIDTH:1] : acc_step[2*WIDTH+1:2];
`else
  assign a_ext     = bus.op_a;
  assign b_ext     = bus.op_b;
  assign last_step = CW'(WIDTH - 1);
  assign product   = acc_step[2*WIDTH:1];
`endif

  assign unused_acc = ^acc_step;

  // One Booth step: add/subtract M into the upper half with a sign guard bit,
  // then the guard bit becomes the arithmetic-shift fill.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    upper_ext = {acc_q[AW-1], acc_q[AW-1:XW+1]};
    m_ext     = {m_q[XW-1], m_q};
    case (acc_q[1:0])
      2'b01:   upper_sum = upper_ext + m_ext;
      2'b10:   upper_sum = upper_ext - m_ext;
      default: upper_sum = upper_ext;
    endcase
    acc_step = {upper_sum, acc_q[XW:1]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (count_q == last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is asynchronous and active-low; all state, including the datapath, clears at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      done_q  <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULT_UNSIGNED_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            m_q     <= a_ext;
            acc_q   <= {{XW{1'b0}}, b_ext, 1'b0};
            count_q <= '0;
`ifdef MULT_UNSIGNED_EN
            uns_q   <= bus.unsigned_op;
`endif
          end
        end
        RUN: begin
          acc_q   <= acc_step;
          count_q <= count_q + 1'b1;
          if (count_q == last_step) begin
            hi_q <= product[2*WIDTH-1:WIDTH];
            lo_q <= product[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: directed table, corner sequences,
// and random operands checked against a plain-arithmetic product model.
module tb_booth_seq_multiplier;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  booth_seq_multiplier_if #(.WIDTH(W)) bus ();

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic uns,
                              input logic [63:0] exp, input string name);
    vec_t v;
    v.a = a; v.b = b; v.uns = uns; v.exp = exp; v.name = name;
    return v;
  endfunction

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic uns);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    return uns ? 64'(ua * ub) : 64'(sa * sb);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive_ops(input logic [31:0] a, input logic [31:0] b, input logic uns);
    bus.op_a = a;
    bus.op_b = b;
`ifdef MULT_UNSIGNED_EN
    bus.unsigned_op = uns;
`else
    if (uns) $display("note: unsigned op requested without MULT_UNSIGNED_EN");
`endif
  endtask

  // Issue one operation once idle; return the product seen with done, the latency in
  // cycles from the start edge (-1 on timeout), and done one cycle later.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic uns,
                        input bit chk_hold, input logic [63:0] hold,
                        output logic [63:0] prod, output int lat, output logic done_after,
                        output bit hold_ok);
    int guard;
    guard   = 0;
    hold_ok = 1'b1;
    @(negedge clk);
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    drive_ops(a, b, uns);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drive_ops($urandom, $urandom, 1'b0);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = c;
        break;
      end
      if (chk_hold && {bus.hi_out, bus.lo_out} !== hold) hold_ok = 1'b0;
    end
    prod = {bus.hi_out, bus.lo_out};
    @(posedge clk);
    #1;
    done_after = bus.done;
  endtask

  initial begin
    logic [63:0] prod;
    int          lat;
    logic        done_after;
    bit          hold_ok;
    int          ndone;
    int          exp_lat;
    logic [31:0] ra, rb;
    logic        ru;

    reset     = 1'b0;
    bus.start = 1'b0;
    drive_ops('0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_prod", {bus.hi_out, bus.lo_out}, 64'd0);
    check("reset_done_busy", {62'd0, bus.done, bus.busy}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    vecs.push_back(mk(32'd7,        32'hFFFFFFFD, 1'b0, 64'hFFFFFFFF_FFFFFFEB, "7_x_m3"));
    vecs.push_back(mk(32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000, "min_x_min"));
    vecs.push_back(mk(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 64'h3FFFFFFF_00000001, "max_x_max"));
    vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h00000000_00000001, "m1_x_m1"));
    vecs.push_back(mk(32'h80000000, 32'd1,        1'b0, 64'hFFFFFFFF_80000000, "min_x_1"));
    vecs.push_back(mk(32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h00000000_80000000, "min_x_m1"));
    vecs.push_back(mk(32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 64'hFFFFFFFF_80000001, "m1_x_max"));
    vecs.push_back(mk(32'd0,        32'hDEADBEEF, 1'b0, 64'd0,                 "zero_x_any"));
`ifdef MULT_UNSIGNED_EN
    vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE_00000001, "multu_max"));
    vecs.push_back(mk(32'h80000000, 32'd2,        1'b1, 64'h00000001_00000000, "multu_2e31x2"));
`endif

    foreach (vecs[i]) begin
      exp_lat = vecs[i].uns ? W + 1 : W;
      run_op(vecs[i].a, vecs[i].b, vecs[i].uns, 1'b0, '0, prod, lat, done_after, hold_ok);
      check({vecs[i].name, "_prod"}, prod, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({vecs[i].name, "_done_1cyc"}, {63'd0, done_after}, 64'd0);
    end

    // Back-to-back: second start in the cycle after done; 30 holds until the new result.
    run_op(32'd5, 32'd6, 1'b0, 1'b0, '0, prod, lat, done_after, hold_ok);
    check("b2b_first", prod, 64'd30);
    run_op(32'hFFFFFFF6, 32'd3, 1'b0, 1'b1, 64'd30, prod, lat, done_after, hold_ok);
    check("b2b_second", prod, 64'hFFFFFFFF_FFFFFFE2);
    check("b2b_latency", 64'(lat), 64'(W));
    check("b2b_hold", {63'd0, hold_ok}, 64'd1);

    // A start issued during RUN must be ignored.
    @(negedge clk);
    drive_ops(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone = 0;
    lat   = -1;
    prod  = '0;
    for (int c = 1; c <= 70; c++) begin
      if (c == 10) begin
        @(negedge clk);
        drive_ops(32'd3, 32'd5, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          lat  = c;
          prod = {bus.hi_out, bus.lo_out};
        end
      end
    end
    check("ign_start_ndone", 64'(ndone), 64'd1);
    check("ign_start_latency", 64'(lat), 64'(W));
    check("ign_start_prod", prod, 64'h3FFFFFFF_00000001);

    // Reset mid-RUN: outputs clear immediately and the abandoned op never reports done.
    @(negedge clk);
    drive_ops(32'h12345678, 32'h9ABCDEF0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrun_reset_prod", {bus.hi_out, bus.lo_out}, 64'd0);
    check("midrun_reset_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("midrun_reset_no_done", 64'(ndone), 64'd0);

    // Random operands against the reference product.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) ra = {ra[31], 31'd0};
      if (i % 6 == 1) rb = {32{rb[0]}};
`ifdef MULT_UNSIGNED_EN
      ru = 1'($urandom_range(0, 1));
`else
      ru = 1'b0;
`endif
      exp_lat = ru ? W + 1 : W;
      run_op(ra, rb, ru, 1'b0, '0, prod, lat, done_after, hold_ok);
      check($sformatf("rand%0d_prod", i), prod, model(ra, rb, ru));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
